md5_core_arbiter: RTL and testbench

- Shares one pipelined md5core between NUM_REQ string-matching requesters.
- Each cycle, picks at most one requester's 152-bit message by round-robin and issues it to the core.
- Records the requester ID in an in-order tag FIFO, then routes each returned digest and message back to the owning requester.
- Sits between the string_process_match instances and md5core.

---
 rtl/md5_core_arbiter_if.sv | 34 +++
 rtl/md5_core_arbiter.sv | 100 ++++++++++
 tb/tb_md5_core_arbiter.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/md5_core_arbiter_if.sv
// Bundle between the requester/md5core side and the arbiter. The master view is the arbiter itself.
interface md5_core_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int TAG_DEPTH = 128,
  parameter int MSG_W     = 152
);
  localparam int CNT_W = $clog2(TAG_DEPTH) + 1;

  logic [NUM_REQ*MSG_W-1:0] req_msg;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [MSG_W-1:0]         md5_msg;
  logic                     md5_msg_valid;
  logic [31:0]              a_ret, b_ret, c_ret, d_ret;
  logic [MSG_W-1:0]         md5_msg_ret;
  logic                     md5_msg_ret_valid;
  logic [31:0]              resp_a, resp_b, resp_c, resp_d;
  logic [MSG_W-1:0]         resp_msg;
  logic [NUM_REQ-1:0]       resp_valid;
  logic [CNT_W-1:0]         outstanding;
  logic                     err_underflow;

  modport master (
    input  req_msg, req_valid, a_ret, b_ret, c_ret, d_ret, md5_msg_ret, md5_msg_ret_valid,
    output req_ready, md5_msg, md5_msg_valid, resp_a, resp_b, resp_c, resp_d, resp_msg,
           resp_valid, outstanding, err_underflow
  );

  modport slave (
    output req_msg, req_valid, a_ret, b_ret, c_ret, d_ret, md5_msg_ret, md5_msg_ret_valid,
    input  req_ready, md5_msg, md5_msg_valid, resp_a, resp_b, resp_c, resp_d, resp_msg,
           resp_valid, outstanding, err_underflow
  );
endinterface

// File: rtl/md5_core_arbiter.sv
// Round-robin sharing of one in-order md5core; 1-cycle issue and 1-cycle return latency.
// Grants stall only when the tag FIFO is full and no result is popping that cycle.
module md5_core_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int TAG_DEPTH = 128,
  parameter int MSG_W     = 152
) (
  input logic                clk,
  input logic                reset,
  md5_core_arbiter_if.master bus
);
  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PTR_W = $clog2(TAG_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(TAG_DEPTH);
  localparam logic [ID_W-1:0]  LAST = ID_W'(NUM_REQ - 1);
  localparam logic [ID_W:0]    NREQ = (ID_W+1)'(NUM_REQ);

  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  win;
  logic             found;
  logic             can_push;
  logic             grant;
  logic             pop;
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  logic [ID_W-1:0]  tag_mem [TAG_DEPTH];

  // Walk from the farthest candidate back to rr_ptr so the nearest valid one is kept.
  always_comb begin
    logic [ID_W:0] sum;
    found = 1'b0;
    win   = '0;
    sum   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (sum >= NREQ) sum = sum - NREQ;
      if (bus.req_valid[sum[ID_W-1:0]]) begin
        found = 1'b1;
        win   = sum[ID_W-1:0];
      end
    end
  end

  // A same-cycle pop frees a slot, so a full FIFO can still accept a grant.
  assign can_push      = (count < FULL) | bus.md5_msg_ret_valid;
  assign grant         = found & can_push & ~reset;
  assign pop           = bus.md5_msg_ret_valid & (count != '0);
  assign bus.req_ready = grant ? (NUM_REQ'(1) << win) : '0;
  assign bus.outstanding = count;

  always_ff @(posedge clk) begin
    if (grant) tag_mem[wr_ptr] <= win;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr            <= '0;
      rd_ptr            <= '0;
      wr_ptr            <= '0;
      count             <= '0;
      bus.md5_msg       <= '0;
      bus.md5_msg_valid <= 1'b0;
      bus.resp_a        <= '0;
      bus.resp_b        <= '0;
      bus.resp_c        <= '0;
      bus.resp_d        <= '0;
      bus.resp_msg      <= '0;
      bus.resp_valid    <= '0;
      bus.err_underflow <= 1'b0;
    end else begin
      bus.md5_msg_valid <= grant;
      if (grant) begin
        bus.md5_msg <= bus.req_msg[win*MSG_W +: MSG_W];
        wr_ptr      <= wr_ptr + 1'b1;
        rr_ptr      <= (win == LAST) ? '0 : win + 1'b1;
      end

      if (pop) begin
        rd_ptr         <= rd_ptr + 1'b1;
        bus.resp_a     <= bus.a_ret;
        bus.resp_b     <= bus.b_ret;
        bus.resp_c     <= bus.c_ret;
        bus.resp_d     <= bus.d_ret;
        bus.resp_msg   <= bus.md5_msg_ret;
        bus.resp_valid <= NUM_REQ'(1) << tag_mem[rd_ptr];
      end else begin
        bus.resp_valid <= '0;
      end

      if (bus.md5_msg_ret_valid && count == '0) bus.err_underflow <= 1'b1;

      case ({grant, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_md5_core_arbiter.sv
// Directed and random checks of md5_core_arbiter against a queue-based model of the arbiter and an in-order core.
module tb_md5_core_arbiter;
  localparam int N   = 4;
  localparam int D   = 16;
  localparam int W   = 152;
  localparam int LAT = 3;

  typedef struct {
    logic [W-1:0] msg;
    int           own;
    int           cyc;
  } flight_t;

  logic clk;
  logic reset;

  md5_core_arbiter_if #(.NUM_REQ(N), .TAG_DEPTH(D), .MSG_W(W)) bus ();
  md5_core_arbiter #(.NUM_REQ(N), .TAG_DEPTH(D), .MSG_W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;
  int cyc_no = 0;

  // Reference state: messages in flight through the core double as the tag FIFO.
  flight_t      pipe[$];
  int           rr;
  logic [W-1:0] exp_md5_msg;
  logic         exp_md5_vld;
  logic [N-1:0] exp_resp_valid;
  logic [31:0]  exp_a, exp_b, exp_c, exp_d;
  logic [W-1:0] exp_rmsg;
  logic         exp_err;
  logic [N-1:0] last_rdy;
  int           obs_grants[N];

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_msg();
    logic [159:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return t[W-1:0];
  endfunction

  function automatic logic [31:0] dig(input logic [W-1:0] m, input int w);
    case (w)
      0:       return m[31:0] ^ 32'h67452301;
      1:       return m[63:32] + 32'hefcdab89;
      2:       return m[95:64] ^ m[127:96];
      default: return {m[151:128], 8'h5a};
    endcase
  endfunction

  task automatic model_clear();
    pipe.delete();
    rr             = 0;
    exp_md5_msg    = '0;
    exp_md5_vld    = 1'b0;
    exp_resp_valid = '0;
    exp_a = '0; exp_b = '0; exp_c = '0; exp_d = '0;
    exp_rmsg       = '0;
    exp_err        = 1'b0;
  endtask

  // One clock: drive after negedge, check the grant combinationally, then check registered outputs after posedge.
  task automatic cycle(input logic [N-1:0] vld, input bit core_en, input bit spur, input bit rst);
    logic [N*W-1:0] msgs;
    logic [W-1:0]   rmsg;
    bit             ret;
    bit             real_ret;
    bit             found;
    bit             can_push;
    int             w;
    int             own;
    logic [N-1:0]   exp_rdy;
    flight_t        f;

    @(negedge clk);
    for (int i = 0; i < N; i++) msgs[i*W +: W] = rand_msg();
    ret = 1'b0; real_ret = 1'b0; rmsg = rand_msg(); own = -1;
    if (!rst) begin
      if (core_en && pipe.size() > 0 && pipe[0].cyc + LAT <= cyc_no) begin
        ret = 1'b1; real_ret = 1'b1; rmsg = pipe[0].msg; own = pipe[0].own;
      end else if (spur) begin
        ret = 1'b1;
      end
    end
    reset                 = rst;
    bus.req_valid         = vld;
    bus.req_msg           = msgs;
    bus.md5_msg_ret_valid = ret;
    bus.md5_msg_ret       = rmsg;
    bus.a_ret = dig(rmsg, 0);
    bus.b_ret = dig(rmsg, 1);
    bus.c_ret = dig(rmsg, 2);
    bus.d_ret = dig(rmsg, 3);

    found = 1'b0; w = 0;
    for (int k = 0; k < N; k++) begin
      if (!found && vld[(rr + k) % N]) begin
        found = 1'b1;
        w = (rr + k) % N;
      end
    end
    can_push = (pipe.size() < D) || ret;
    exp_rdy  = (!rst && found && can_push) ? N'(1 << w) : '0;
    #1;
    last_rdy = bus.req_ready;
    for (int i = 0; i < N; i++) if (last_rdy[i]) obs_grants[i]++;
    check("req_ready", bus.req_ready, exp_rdy);

    @(posedge clk);
    #1;
    if (rst) begin
      model_clear();
    end else begin
      if (real_ret) begin
        f = pipe.pop_front();
        exp_resp_valid = N'(1 << own);
        exp_rmsg = rmsg;
        exp_a = dig(rmsg, 0); exp_b = dig(rmsg, 1);
        exp_c = dig(rmsg, 2); exp_d = dig(rmsg, 3);
      end else begin
        exp_resp_valid = '0;
        if (ret) exp_err = 1'b1;
      end
      if (exp_rdy != '0) begin
        exp_md5_msg = msgs[w*W +: W];
        exp_md5_vld = 1'b1;
        f.msg = exp_md5_msg; f.own = w; f.cyc = cyc_no;
        pipe.push_back(f);
        rr = (w + 1) % N;
      end else begin
        exp_md5_vld = 1'b0;
      end
    end
    cyc_no++;

    check("md5_msg_valid", bus.md5_msg_valid, exp_md5_vld);
    check("md5_msg", bus.md5_msg, exp_md5_msg);
    check("resp_valid", bus.resp_valid, exp_resp_valid);
    check("resp_a", bus.resp_a, exp_a);
    check("resp_b", bus.resp_b, exp_b);
    check("resp_c", bus.resp_c, exp_c);
    check("resp_d", bus.resp_d, exp_d);
    check("resp_msg", bus.resp_msg, exp_rmsg);
    check("err_underflow", bus.err_underflow, exp_err);
    check("outstanding", bus.outstanding, W'(pipe.size()));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (pipe.size() > 0 && n < 100) begin
      cycle('0, 1'b1, 1'b0, 1'b0);
      n++;
    end
    check("drained", bus.outstanding, '0);
  endtask

  initial begin
    int n;
    reset                 = 1'b1;
    bus.req_valid         = '0;
    bus.req_msg           = '0;
    bus.md5_msg_ret_valid = 1'b0;
    bus.md5_msg_ret       = '0;
    bus.a_ret = '0; bus.b_ret = '0; bus.c_ret = '0; bus.d_ret = '0;
    model_clear();

    // Reset state.
    cycle('0, 1'b0, 1'b0, 1'b1);
    cycle('0, 1'b0, 1'b0, 1'b1);
    check("reset_outstanding", bus.outstanding, '0);
    check("reset_md5_vld", bus.md5_msg_valid, '0);
    check("reset_resp_valid", bus.resp_valid, '0);

    // Single requester, response returns to its owner.
    cycle(4'b0100, 1'b1, 1'b0, 1'b0);
    check("single_ready", last_rdy, 4'b0100);
    n = 0;
    while (bus.resp_valid === '0 && n < 20) begin
      cycle('0, 1'b1, 1'b0, 1'b0);
      n++;
    end
    check("single_resp_valid", bus.resp_valid, 4'b0100);
    drain();

    // All requesters valid for 100 issues: equal share.
    for (int i = 0; i < N; i++) obs_grants[i] = 0;
    for (int i = 0; i < 100; i++) cycle('1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < N; i++) check("rr_share", W'(obs_grants[i]), W'(25));
    drain();

    // Sparse round robin from pointer 2.
    cycle(4'b0010, 1'b1, 1'b0, 1'b0);
    cycle(4'b0011, 1'b1, 1'b0, 1'b0);
    check("sparse_first", last_rdy, 4'b0001);
    cycle(4'b0011, 1'b1, 1'b0, 1'b0);
    check("sparse_second", last_rdy, 4'b0010);
    drain();

    // Full FIFO with stalled core, then a return frees a slot in the same cycle.
    for (int i = 0; i < D + 2; i++) cycle('1, 1'b0, 1'b0, 1'b0);
    check("full_count", bus.outstanding, W'(D));
    check("full_no_ready", last_rdy, '0);
    cycle('1, 1'b1, 1'b0, 1'b0);
    check("full_ret_grant", W'(last_rdy != '0), W'(1));
    check("full_count_hold", bus.outstanding, W'(D));
    drain();

    // Underflow is sticky.
    cycle('0, 1'b0, 1'b1, 1'b0);
    check("underflow_flag", bus.err_underflow, 1'b1);
    check("underflow_no_resp", bus.resp_valid, '0);
    for (int i = 0; i < 3; i++) cycle('0, 1'b0, 1'b0, 1'b0);
    check("underflow_sticky", bus.err_underflow, 1'b1);

    // Reset with 10 outstanding.
    for (int i = 0; i < 10; i++) cycle('1, 1'b0, 1'b0, 1'b0);
    check("pre_reset_count", bus.outstanding, W'(10));
    cycle('1, 1'b0, 1'b0, 1'b1);
    check("post_reset_count", bus.outstanding, '0);
    check("post_reset_err", bus.err_underflow, '0);
    check("post_reset_msg", bus.md5_msg, '0);
    check("post_reset_resp_msg", bus.resp_msg, '0);
    cycle('1, 1'b1, 1'b0, 1'b0);
    check("resume_ready", last_rdy, 4'b0001);
    drain();

    // Random traffic with an intermittently stalled core.
    for (int i = 0; i < 400; i++)
      cycle(N'($urandom), ($urandom_range(0, 3) != 0), 1'b0, 1'b0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
